// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the UART RX frame counter and sampler.
package uart_rx_pkg;

    typedef enum logic [1:0] {IDLE, COUNT, ERR} state_t;

    localparam int MIN_DATA_BITS = 5;
    localparam int MAX_DATA_BITS = 9;
    localparam int MIN_PRESCALE  = 4;

    // Start bit + data + optional parity + one or two stop bits.
    function automatic int frame_len(input logic [3:0] dl, input logic par, input logic s2);
        return 1 + int'(dl) + int'(par) + (s2 ? 2 : 1);
    endfunction

endpackage

// File: rtl/uart_rx_sample_window.sv
// Mid-bit sampling window decode: mid = P>>1, window covers mid-1..mid+1.
module uart_rx_sample_window #(
    parameter int PRESCALE_WIDTH = 6
) (
    input  logic [PRESCALE_WIDTH-1:0] edge_cnt,
    input  logic [PRESCALE_WIDTH-1:0] prescale,
    output logic                      sample_en,
    output logic                      sample_mid
);

    // One extra bit so mid+1 cannot wrap; P >= 4 keeps mid-1 non-negative.
    logic [PRESCALE_WIDTH:0] mid;
    logic [PRESCALE_WIDTH:0] edge_x;

    assign mid    = {1'b0, prescale} >> 1;
    assign edge_x = {1'b0, edge_cnt};

    assign sample_mid = (edge_x == mid);
    assign sample_en  = (edge_x + 1'b1 >= mid) && (edge_x <= mid + 1'b1);

endmodule

// File: rtl/uart_rx_frame_counter.sv
// Edge and bit-position counter for the UART receiver with runtime frame format.
module uart_rx_frame_counter
    import uart_rx_pkg::*;
#(
    parameter int PRESCALE_WIDTH = 6,
    parameter int MIN_DATA_BITS  = uart_rx_pkg::MIN_DATA_BITS,
    parameter int MAX_DATA_BITS  = uart_rx_pkg::MAX_DATA_BITS,
    parameter int BIT_CNT_WIDTH  = 4
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      enable,
    input  logic [PRESCALE_WIDTH-1:0] Prescale,
    input  logic [3:0]                data_len,
    input  logic                      PAR_EN,
    input  logic                      stop2,
    output logic [BIT_CNT_WIDTH-1:0]  bit_cnt,
    output logic [PRESCALE_WIDTH-1:0] edge_cnt,
    output logic                      sample_en,
    output logic                      sample_mid,
    output logic                      bit_done,
    output logic                      frame_done,
    output logic                      cfg_err
);

    state_t state, state_next;

    logic [PRESCALE_WIDTH-1:0] p_q;
    logic [3:0]                dl_q;
    logic                      par_q;
    logic                      s2_q;
    logic [BIT_CNT_WIDTH-1:0]  last;
    logic                      cfg_ok;
    logic                      edge_wrap;
    logic                      at_last;
    logic                      win_en;
    logic                      win_mid;

    assign cfg_ok = (Prescale >= PRESCALE_WIDTH'(MIN_PRESCALE))
                 && (data_len >= 4'(MIN_DATA_BITS))
                 && (data_len <= 4'(MAX_DATA_BITS));

    assign last      = BIT_CNT_WIDTH'(frame_len(dl_q, par_q, s2_q) - 1);
    // edge_cnt >= P-1 without forming P-1 in a narrower width.
    assign edge_wrap = ({1'b0, edge_cnt} + 1'b1) >= {1'b0, p_q};
    assign at_last   = (bit_cnt >= last);

    always_ff @(posedge CLK) begin
        if (RST) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (enable) state_next = cfg_ok ? COUNT : ERR;
            COUNT: begin
                if (!enable)                              state_next = IDLE;
                else if (edge_wrap && at_last && !cfg_ok) state_next = ERR;
            end
            ERR:     if (!enable) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            bit_cnt    <= '0;
            edge_cnt   <= '0;
            bit_done   <= 1'b0;
            frame_done <= 1'b0;
            cfg_err    <= 1'b0;
            p_q        <= '0;
            dl_q       <= '0;
            par_q      <= 1'b0;
            s2_q       <= 1'b0;
        end else begin
            bit_done   <= 1'b0;
            frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    bit_cnt  <= '0;
                    edge_cnt <= '0;
                    cfg_err  <= 1'b0;
                    if (enable) begin
                        if (cfg_ok) begin
                            p_q      <= Prescale;
                            dl_q     <= data_len;
                            par_q    <= PAR_EN;
                            s2_q     <= stop2;
                            edge_cnt <= PRESCALE_WIDTH'(1);
                        end else begin
                            cfg_err  <= 1'b1;
                        end
                    end
                end
                COUNT: begin
                    if (!enable) begin
                        bit_cnt  <= '0;
                        edge_cnt <= '0;
                    end else if (!edge_wrap) begin
                        edge_cnt <= edge_cnt + 1'b1;
                    end else begin
                        edge_cnt <= '0;
                        bit_done <= 1'b1;
                        if (!at_last) begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end else begin
                            // Frame boundary: pick up any config change made mid-frame.
                            bit_cnt    <= '0;
                            frame_done <= 1'b1;
                            if (cfg_ok) begin
                                p_q   <= Prescale;
                                dl_q  <= data_len;
                                par_q <= PAR_EN;
                                s2_q  <= stop2;
                            end else begin
                                cfg_err <= 1'b1;
                            end
                        end
                    end
                end
                ERR: begin
                    bit_cnt  <= '0;
                    edge_cnt <= '0;
                    if (!enable) cfg_err <= 1'b0;
                end
                default: begin
                    bit_cnt  <= '0;
                    edge_cnt <= '0;
                end
            endcase
        end
    end

    uart_rx_sample_window #(.PRESCALE_WIDTH(PRESCALE_WIDTH)) u_window (
        .edge_cnt   (edge_cnt),
        .prescale   (p_q),
        .sample_en  (win_en),
        .sample_mid (win_mid)
    );

    always_comb begin
        sample_en  = 1'b0;
        sample_mid = 1'b0;
        if (state == COUNT) begin
            sample_en  = win_en;
            sample_mid = win_mid;
        end
    end

endmodule
